// File: rtl/gpu_net_iface.sv
// gpu_net_iface
// Network interface for one GPU node, placed between the node core and its
// router port.
//   TX path: local {dest, payload} requests are packed into flits
//            {dest, payload}, queued in a TX FIFO and offered to the router.
//            The router handshake is net_valid_out / net_ready_in.
//   RX path: inbound flits are accepted whenever the RX FIFO has room.
//            A flit addressed to NODE_ID has its payload queued for the
//            local consumer. Any other flit is discarded and counted in a
//            saturating 8-bit drop counter.
//
// Parameters
//   NODE_ID   : this node's ID. Must be below 2**ID_W - 1.
//   ID_W      : width of the destination field.
//   PAYLOAD_W : width of the payload field.
//   TX_DEPTH  : number of TX FIFO entries. Power of two, at least 2.
//   RX_DEPTH  : number of RX FIFO entries. Power of two, at least 2.
//
// Ports
//   ACLK, ARESETn              : clock and asynchronous active-low reset.
//   tx_dest/tx_payload/tx_valid/tx_ready
//                              : local send request.
//   net_data_out/net_valid_out/net_ready_in
//                              : outbound flit to the router.
//   net_data_in/net_valid_in/net_ready_out
//                              : inbound flit from the router.
//   rx_payload/rx_valid/rx_ready
//                              : head of the RX FIFO, presented to the consumer.
//   drop_count                 : number of discarded inbound flits.
//                                Saturates at 255.
//
// Optional feature, selected by the macro GPU_NET_BCAST_EN:
//   When defined, an all-ones dest is the broadcast ID. Such flits are
//   delivered like a local match and are not counted as drops.
//   When undefined, an all-ones dest is misaddressed.
module gpu_net_iface #(
  parameter int NODE_ID   = 29,
  parameter int ID_W      = 6,
  parameter int PAYLOAD_W = 10,
  parameter int TX_DEPTH  = 4,
  parameter int RX_DEPTH  = 4
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [ID_W-1:0]           tx_dest,
  input  logic [PAYLOAD_W-1:0]      tx_payload,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [ID_W+PAYLOAD_W-1:0] net_data_out,
  output logic                      net_valid_out,
  input  logic                      net_ready_in,
  input  logic [ID_W+PAYLOAD_W-1:0] net_data_in,
  input  logic                      net_valid_in,
  output logic                      net_ready_out,
  output logic [PAYLOAD_W-1:0]      rx_payload,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic [7:0]                drop_count
);

  localparam int FLIT_W = ID_W + PAYLOAD_W;
  localparam int TX_AW  = $clog2(TX_DEPTH);
  localparam int RX_AW  = $clog2(RX_DEPTH);

  localparam logic [ID_W-1:0] MY_ID = ID_W'(NODE_ID);
`ifdef GPU_NET_BCAST_EN
  localparam logic [ID_W-1:0] BCAST_ID = '1;
`endif

  localparam logic [TX_AW:0] TX_ONE    = {{TX_AW{1'b0}}, 1'b1};
  localparam logic [RX_AW:0] RX_ONE    = {{RX_AW{1'b0}}, 1'b1};
  // The pointers carry one extra wrap bit. The FIFO is full when the
  // pointers differ in that bit only.
  localparam logic [TX_AW:0] TX_FULL_X = {1'b1, {TX_AW{1'b0}}};
  localparam logic [RX_AW:0] RX_FULL_X = {1'b1, {RX_AW{1'b0}}};

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // TX FIFO
  logic [FLIT_W-1:0] tx_mem_q [TX_DEPTH];
  logic [TX_AW:0]    tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic              tx_empty, tx_full, tx_push, tx_pop;

  assign tx_empty      = (tx_wr_q == tx_rd_q);
  assign tx_full       = ((tx_wr_q ^ tx_rd_q) == TX_FULL_X);
  assign tx_ready      = !tx_full;
  assign net_valid_out = !tx_empty;
  // The storage is not reset. Gating the output with "empty" makes it read
  // as zero out of reset, and never exposes stale entries.
  assign net_data_out  = tx_empty ? '0 : tx_mem_q[tx_rd_q[TX_AW-1:0]];

  assign tx_push = tx_valid && tx_ready;
  assign tx_pop  = net_valid_out && net_ready_in;
  assign tx_wr_d = tx_push ? tx_wr_q + TX_ONE : tx_wr_q;
  assign tx_rd_d = tx_pop  ? tx_rd_q + TX_ONE : tx_rd_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
    end else begin
      tx_wr_q <= tx_wr_d;
      tx_rd_q <= tx_rd_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (tx_push) tx_mem_q[tx_wr_q[TX_AW-1:0]] <= {tx_dest, tx_payload};
  end

  // RX filter and RX FIFO
  logic [PAYLOAD_W-1:0] rx_mem_q [RX_DEPTH];
  logic [RX_AW:0]       rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic                 rx_empty, rx_full, rx_accept, rx_match, rx_push, rx_pop, rx_drop;
  logic [ID_W-1:0]      rx_dest;
  logic [7:0]           drop_q, drop_d;

  assign rx_empty      = (rx_wr_q == rx_rd_q);
  assign rx_full       = ((rx_wr_q ^ rx_rd_q) == RX_FULL_X);
  // Readiness depends only on occupancy, never on the flit's destination.
  // A misaddressed flit is therefore still held off while the RX FIFO is full.
  assign net_ready_out = !rx_full;
  assign rx_valid      = !rx_empty;
  assign rx_payload    = rx_empty ? '0 : rx_mem_q[rx_rd_q[RX_AW-1:0]];

  assign rx_dest = net_data_in[FLIT_W-1:PAYLOAD_W];
`ifdef GPU_NET_BCAST_EN
  assign rx_match = (rx_dest == MY_ID) || (rx_dest == BCAST_ID);
`else
  assign rx_match = (rx_dest == MY_ID);
`endif

  assign rx_accept = net_valid_in && net_ready_out;
  assign rx_push   = rx_accept && rx_match;
  assign rx_drop   = rx_accept && !rx_match;
  assign rx_pop    = rx_valid && rx_ready;
  assign rx_wr_d   = rx_push ? rx_wr_q + RX_ONE : rx_wr_q;
  assign rx_rd_d   = rx_pop  ? rx_rd_q + RX_ONE : rx_rd_q;
  assign drop_d    = rx_drop ? sat_inc8(drop_q) : drop_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rx_wr_q <= '0;
      rx_rd_q <= '0;
      drop_q  <= '0;
    end else begin
      rx_wr_q <= rx_wr_d;
      rx_rd_q <= rx_rd_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (rx_push) rx_mem_q[rx_wr_q[RX_AW-1:0]] <= net_data_in[PAYLOAD_W-1:0];
  end

  assign drop_count = drop_q;

endmodule
